// File: rtl/clock_pkg.sv
// Shared definitions for the clock/alarm slice: state encoding, BCD digit widths, time limits.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package clock_pkg;

    // Alarm controller state encoding; SNOOZE is only reachable with ALARM_SNOOZE_EN.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SET_HOUR = 3'd1,
        SET_MIN  = 3'd2,
        RINGING  = 3'd3,
        SNOOZE   = 3'd4
    } alarm_state_t;

    localparam int UNITS_W     = 4;
    localparam int TENS_MIN_W  = 3;
    localparam int TENS_HOUR_W = 2;

    localparam int HOUR_MAX = 23;
    localparam int MIN_MAX  = 59;

    localparam logic [TENS_HOUR_W-1:0] HOUR_MAX_TENS  = TENS_HOUR_W'(HOUR_MAX / 10);
    localparam logic [UNITS_W-1:0]     HOUR_MAX_UNITS = UNITS_W'(HOUR_MAX % 10);
    localparam logic [TENS_MIN_W-1:0]  MIN_MAX_TENS   = TENS_MIN_W'(MIN_MAX / 10);
    localparam logic [UNITS_W-1:0]     BCD_DIGIT_MAX  = 4'd9;

    // HH:MM packed most-significant digit first, so equality compares the whole time.
    typedef struct packed {
        logic [TENS_HOUR_W-1:0] tens_hour;
        logic [UNITS_W-1:0]     units_hour;
        logic [TENS_MIN_W-1:0]  tens_min;
        logic [UNITS_W-1:0]     units_min;
    } bcd_time_t;

endpackage

// File: rtl/alarm_controller_if.sv
// Signal bundle between the alarm controller and its surroundings (buttons, live time, display, buzzer).
// Latency: n/a (wiring only).
// Backpressure: none; all inputs are single-cycle pulses or levels.
interface alarm_controller_if;
    import clock_pkg::*;

    logic                   i_Tick_1Hz;
    logic                   i_Tone;
    logic                   i_Button_Alarm;
    logic                   i_Button_Up;
    logic                   i_Button_Arm;
    logic [UNITS_W-1:0]     i_Units_Min;
    logic [TENS_MIN_W-1:0]  i_Tens_Min;
    logic [UNITS_W-1:0]     i_Units_Hour;
    logic [TENS_HOUR_W-1:0] i_Tens_Hour;

    logic [UNITS_W-1:0]     o_Alarm_Units_Min;
    logic [TENS_MIN_W-1:0]  o_Alarm_Tens_Min;
    logic [UNITS_W-1:0]     o_Alarm_Units_Hour;
    logic [TENS_HOUR_W-1:0] o_Alarm_Tens_Hour;
    logic                   o_Display_Select;
    logic [1:0]             o_Display_Enable_Digits;
    logic                   o_Armed;
    logic                   o_Ringing;
    logic                   o_Buzzer;

    // Environment side: drives buttons, ticks and live time, observes alarm outputs.
    modport master (
        output i_Tick_1Hz, i_Tone, i_Button_Alarm, i_Button_Up, i_Button_Arm,
        output i_Units_Min, i_Tens_Min, i_Units_Hour, i_Tens_Hour,
        input  o_Alarm_Units_Min, o_Alarm_Tens_Min, o_Alarm_Units_Hour, o_Alarm_Tens_Hour,
        input  o_Display_Select, o_Display_Enable_Digits, o_Armed, o_Ringing, o_Buzzer
    );

    // Alarm controller side.
    modport slave (
        input  i_Tick_1Hz, i_Tone, i_Button_Alarm, i_Button_Up, i_Button_Arm,
        input  i_Units_Min, i_Tens_Min, i_Units_Hour, i_Tens_Hour,
        output o_Alarm_Units_Min, o_Alarm_Tens_Min, o_Alarm_Units_Hour, o_Alarm_Tens_Hour,
        output o_Display_Select, o_Display_Enable_Digits, o_Armed, o_Ringing, o_Buzzer
    );

endinterface

// File: rtl/alarm_time_reg.sv
// Four-digit BCD HH:MM register with independent hour/minute increment strobes (24 h wrap, no carry).
// Latency: one cycle from strobe to updated digits.
// Backpressure: none; every strobe is applied.
module alarm_time_reg
    import clock_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      inc_hour,
    input  logic      inc_min,
    output bcd_time_t value
);

    // Hours wrap 23->00, minutes wrap 59->00; minute wrap never touches the hour.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
        end else begin
            if (inc_hour) begin
                if (value.tens_hour == HOUR_MAX_TENS && value.units_hour == HOUR_MAX_UNITS) begin
                    value.tens_hour  <= '0;
                    value.units_hour <= '0;
                end else if (value.units_hour == BCD_DIGIT_MAX) begin
                    value.units_hour <= '0;
                    value.tens_hour  <= value.tens_hour + 1'b1;
                end else begin
                    value.units_hour <= value.units_hour + 1'b1;
                end
            end
            if (inc_min) begin
                if (value.units_min == BCD_DIGIT_MAX) begin
                    value.units_min <= '0;
                    value.tens_min  <= (value.tens_min == MIN_MAX_TENS) ? '0 : value.tens_min + 1'b1;
                end else begin
                    value.units_min <= value.units_min + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/alarm_controller.sv
// Alarm scheduler: set/arm/ring/timeout sequencing, display select, blink enables, buzzer gating. ALARM_SNOOZE_EN adds SNOOZE.
// Latency: all outputs registered; a state change shows one cycle after the causing pulse.
// Backpressure: none; pulses arriving in a state that does not use them are dropped.
module alarm_controller
    import clock_pkg::*;
#(
    parameter int RING_SEC    = 60,
    parameter int TIMEOUT_SEC = 10
`ifdef ALARM_SNOOZE_EN
    ,
    parameter int SNOOZE_SEC  = 300
`endif
) (
    input logic               i_Clock,
    input logic               i_Reset,
    alarm_controller_if.slave bus
);

    localparam int RING_W = $clog2(RING_SEC + 1);
    localparam int TOUT_W = $clog2(TIMEOUT_SEC + 1);

    alarm_state_t      state;
    logic [RING_W-1:0] ring_cnt;
    logic [TOUT_W-1:0] tout_cnt;
    logic              beat;
    logic              match_q;
`ifdef ALARM_SNOOZE_EN
    localparam int SNZ_W = $clog2(SNOOZE_SEC + 1);
    logic [SNZ_W-1:0]  snz_cnt;
`endif

    bcd_time_t alarm_time;
    bcd_time_t live_time;
    logic      any_btn;
    logic      match_now;
    logic      match_rise;
    logic      inc_hour;
    logic      inc_min;
    logic [1:0] set_blink;

    assign live_time  = {bus.i_Tens_Hour, bus.i_Units_Hour, bus.i_Tens_Min, bus.i_Units_Min};
    assign any_btn    = bus.i_Button_Alarm | bus.i_Button_Up | bus.i_Button_Arm;
    assign match_now  = bus.o_Armed && (live_time == alarm_time);
    assign match_rise = match_now && !match_q;
    // Alarm beats Up when both arrive together, so the increment is suppressed.
    assign inc_hour   = (state == SET_HOUR) && bus.i_Button_Up && !bus.i_Button_Alarm;
    assign inc_min    = (state == SET_MIN)  && bus.i_Button_Up && !bus.i_Button_Alarm;
    assign set_blink  = (state == SET_HOUR) ? 2'b10 : 2'b01;

    alarm_time_reg u_time (
        .clk      (i_Clock),
        .rst      (i_Reset),
        .inc_hour (inc_hour),
        .inc_min  (inc_min),
        .value    (alarm_time)
    );

    assign bus.o_Alarm_Tens_Hour  = alarm_time.tens_hour;
    assign bus.o_Alarm_Units_Hour = alarm_time.units_hour;
    assign bus.o_Alarm_Tens_Min   = alarm_time.tens_min;
    assign bus.o_Alarm_Units_Min  = alarm_time.units_min;

    // Match history, updated in every state so leaving set mode mid-match cannot ring.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) match_q <= 1'b0;
        else         match_q <= match_now;
    end

    // Main FSM; outputs default low each cycle and each branch sets what its next state shows.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state                       <= IDLE;
            ring_cnt                    <= '0;
            tout_cnt                    <= '0;
            beat                        <= 1'b0;
            bus.o_Armed                 <= 1'b0;
            bus.o_Ringing               <= 1'b0;
            bus.o_Buzzer                <= 1'b0;
            bus.o_Display_Select        <= 1'b0;
            bus.o_Display_Enable_Digits <= 2'b00;
`ifdef ALARM_SNOOZE_EN
            snz_cnt                     <= '0;
`endif
        end else begin
            bus.o_Display_Select        <= 1'b0;
            bus.o_Display_Enable_Digits <= 2'b00;
            bus.o_Ringing               <= 1'b0;
            bus.o_Buzzer                <= 1'b0;
            case (state)
                IDLE: begin
                    if (match_rise) begin
                        state         <= RINGING;
                        ring_cnt      <= '0;
                        beat          <= 1'b1;
                        bus.o_Ringing <= 1'b1;
                        bus.o_Buzzer  <= bus.i_Tone;
                    end else if (bus.i_Button_Alarm) begin
                        state                       <= SET_HOUR;
                        tout_cnt                    <= '0;
                        bus.o_Display_Select        <= 1'b1;
                        bus.o_Display_Enable_Digits <= 2'b10;
                    end else if (bus.i_Button_Arm) begin
                        bus.o_Armed <= !bus.o_Armed;
                    end
                end
                SET_HOUR, SET_MIN: begin
                    if (bus.i_Button_Alarm) begin
                        tout_cnt <= '0;
                        if (state == SET_HOUR) begin
                            state                       <= SET_MIN;
                            bus.o_Display_Select        <= 1'b1;
                            bus.o_Display_Enable_Digits <= 2'b01;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (any_btn) begin
                        tout_cnt                    <= '0;
                        bus.o_Display_Select        <= 1'b1;
                        bus.o_Display_Enable_Digits <= set_blink;
                    end else if (bus.i_Tick_1Hz && tout_cnt == TOUT_W'(TIMEOUT_SEC - 1)) begin
                        state <= IDLE;
                    end else begin
                        if (bus.i_Tick_1Hz) tout_cnt <= tout_cnt + 1'b1;
                        bus.o_Display_Select        <= 1'b1;
                        bus.o_Display_Enable_Digits <= set_blink;
                    end
                end
                RINGING: begin
                    if (bus.i_Button_Arm || bus.i_Button_Alarm) begin
                        state <= IDLE;
`ifdef ALARM_SNOOZE_EN
                    end else if (bus.i_Button_Up) begin
                        state   <= SNOOZE;
                        snz_cnt <= '0;
`endif
                    end else if (bus.i_Tick_1Hz && ring_cnt == RING_W'(RING_SEC - 1)) begin
                        state <= IDLE;
                    end else begin
                        bus.o_Ringing <= 1'b1;
                        if (bus.i_Tick_1Hz) begin
                            ring_cnt     <= ring_cnt + 1'b1;
                            beat         <= !beat;
                            bus.o_Buzzer <= !beat && bus.i_Tone;
                        end else begin
                            bus.o_Buzzer <= beat && bus.i_Tone;
                        end
                    end
                end
`ifdef ALARM_SNOOZE_EN
                SNOOZE: begin
                    if (bus.i_Button_Arm) begin
                        state <= IDLE;
                    end else if (bus.i_Tick_1Hz && snz_cnt == SNZ_W'(SNOOZE_SEC - 1)) begin
                        state         <= RINGING;
                        ring_cnt      <= '0;
                        beat          <= 1'b1;
                        bus.o_Ringing <= 1'b1;
                        bus.o_Buzzer  <= bus.i_Tone;
                    end else if (bus.i_Tick_1Hz) begin
                        snz_cnt <= snz_cnt + 1'b1;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alarm_controller.sv
// Directed bench for alarm_controller with an integer-arithmetic behavioural model checked every cycle.
// Latency: model predicts post-edge outputs; comparison happens on the falling edge.
// Backpressure: n/a.
module tb_alarm_controller;

    localparam int T_RING    = 60;
    localparam int T_TIMEOUT = 10;
    localparam int T_SNOOZE  = 3;

    localparam int M_IDLE = 0;
    localparam int M_SETH = 1;
    localparam int M_SETM = 2;
    localparam int M_RING = 3;
    localparam int M_SNZ  = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic chk_en = 1'b0;
    logic [1:0] tone_cnt = 2'd0;

    int n_vec = 0;
    int n_err = 0;
    int w;

    // Model state: plain integers for times and seconds.
    int m_mode, m_hh, m_mm, m_idle, m_ring, m_snz;
    bit m_armed, m_prev_match, m_tone, m_match, m_rise;
    int live_hh, live_mm;

    alarm_controller_if bus ();

`ifdef ALARM_SNOOZE_EN
    alarm_controller #(.RING_SEC(T_RING), .TIMEOUT_SEC(T_TIMEOUT), .SNOOZE_SEC(T_SNOOZE)) dut (
        .i_Clock (clk),
        .i_Reset (rst),
        .bus     (bus)
    );
`else
    alarm_controller #(.RING_SEC(T_RING), .TIMEOUT_SEC(T_TIMEOUT)) dut (
        .i_Clock (clk),
        .i_Reset (rst),
        .bus     (bus)
    );
`endif

    initial forever #5 clk = ~clk;

    // Tone source: square wave with a 4-cycle period.
    initial begin
        bus.i_Tone = 1'b0;
        forever begin
            @(negedge clk);
            tone_cnt    = tone_cnt + 2'd1;
            bus.i_Tone  = tone_cnt[1];
        end
    end

    // Behavioural model, stepped on every rising edge from the inputs presented to that edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode = M_IDLE; m_hh = 0; m_mm = 0; m_idle = 0; m_ring = 0; m_snz = 0;
            m_armed = 0; m_prev_match = 0; m_tone = 0;
        end else begin
            live_hh = 10 * int'(bus.i_Tens_Hour) + int'(bus.i_Units_Hour);
            live_mm = 10 * int'(bus.i_Tens_Min) + int'(bus.i_Units_Min);
            m_match = m_armed && (live_hh == m_hh) && (live_mm == m_mm);
            m_rise  = m_match && !m_prev_match;
            m_prev_match = m_match;
            m_tone  = bus.i_Tone;
            case (m_mode)
                M_IDLE: begin
                    if (m_rise) begin m_mode = M_RING; m_ring = 0; end
                    else if (bus.i_Button_Alarm) begin m_mode = M_SETH; m_idle = 0; end
                    else if (bus.i_Button_Arm) m_armed = !m_armed;
                end
                M_SETH, M_SETM: begin
                    if (bus.i_Button_Alarm) begin
                        m_mode = (m_mode == M_SETH) ? M_SETM : M_IDLE;
                        m_idle = 0;
                    end else if (bus.i_Button_Up || bus.i_Button_Arm) begin
                        if (bus.i_Button_Up) begin
                            if (m_mode == M_SETH) m_hh = (m_hh + 1) % 24;
                            else                  m_mm = (m_mm + 1) % 60;
                        end
                        m_idle = 0;
                    end else if (bus.i_Tick_1Hz) begin
                        m_idle = m_idle + 1;
                        if (m_idle == T_TIMEOUT) m_mode = M_IDLE;
                    end
                end
                M_RING: begin
                    if (bus.i_Button_Arm || bus.i_Button_Alarm) m_mode = M_IDLE;
`ifdef ALARM_SNOOZE_EN
                    else if (bus.i_Button_Up) begin m_mode = M_SNZ; m_snz = 0; end
`endif
                    else if (bus.i_Tick_1Hz) begin
                        m_ring = m_ring + 1;
                        if (m_ring == T_RING) m_mode = M_IDLE;
                    end
                end
                M_SNZ: begin
                    if (bus.i_Button_Arm) m_mode = M_IDLE;
                    else if (bus.i_Tick_1Hz) begin
                        m_snz = m_snz + 1;
                        if (m_snz == T_SNOOZE) begin m_mode = M_RING; m_ring = 0; end
                    end
                end
                default: m_mode = M_IDLE;
            endcase
        end
    end

    function automatic logic [18:0] exp_vec();
        logic [1:0] blink;
        logic       buzz;
        blink = (m_mode == M_SETH) ? 2'b10 : (m_mode == M_SETM) ? 2'b01 : 2'b00;
        // Beat is high on an even count of elapsed ring seconds.
        buzz  = (m_mode == M_RING) && (m_ring % 2 == 0) && m_tone;
        return {2'(m_hh / 10), 4'(m_hh % 10), 3'(m_mm / 10), 4'(m_mm % 10),
                (m_mode == M_SETH || m_mode == M_SETM), blink, m_armed, (m_mode == M_RING), buzz};
    endfunction

    function automatic logic [18:0] dut_vec();
        return {bus.o_Alarm_Tens_Hour, bus.o_Alarm_Units_Hour, bus.o_Alarm_Tens_Min, bus.o_Alarm_Units_Min,
                bus.o_Display_Select, bus.o_Display_Enable_Digits, bus.o_Armed, bus.o_Ringing, bus.o_Buzzer};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input bit a, input bit u, input bit r);
        bus.i_Button_Alarm = a; bus.i_Button_Up = u; bus.i_Button_Arm = r;
        @(negedge clk);
        bus.i_Button_Alarm = 1'b0; bus.i_Button_Up = 1'b0; bus.i_Button_Arm = 1'b0;
    endtask

    task automatic ups(input int n);
        for (int k = 0; k < n; k++) pulse(0, 1, 0);
    endtask

    task automatic tick();
        bus.i_Tick_1Hz = 1'b1;
        @(negedge clk);
        bus.i_Tick_1Hz = 1'b0;
        cyc(2);
    endtask

    task automatic set_live(input int hh, input int mm);
        bus.i_Tens_Hour  = 2'(hh / 10);
        bus.i_Units_Hour = 4'(hh % 10);
        bus.i_Tens_Min   = 3'(mm / 10);
        bus.i_Units_Min  = 4'(mm % 10);
    endtask

    function automatic logic [12:0] alarm_digits();
        return {bus.o_Alarm_Tens_Hour, bus.o_Alarm_Units_Hour, bus.o_Alarm_Tens_Min, bus.o_Alarm_Units_Min};
    endfunction

    initial begin
        bus.i_Tick_1Hz = 0; bus.i_Button_Alarm = 0; bus.i_Button_Up = 0; bus.i_Button_Arm = 0;
        set_live(0, 0);
        #1 rst = 1'b1;
        cyc(2);

        // Every-cycle comparison against the model while out of reset.
        fork
            forever begin
                @(negedge clk);
                if (chk_en && !rst) begin
                    n_vec = n_vec + 1;
                    if (dut_vec() !== exp_vec()) begin
                        n_err = n_err + 1;
                        $display("FAIL cycle_model: got %05h expected %05h at %0t", dut_vec(), exp_vec(), $time);
                    end
                end
            end
        join_none

        check("reset_alarm_time", 32'(alarm_digits()), 0);
        check("reset_armed", 32'(bus.o_Armed), 0);
        check("reset_buzzer", 32'(bus.o_Buzzer), 0);
        check("reset_display", 32'({bus.o_Display_Select, bus.o_Display_Enable_Digits, bus.o_Ringing}), 0);
        rst = 1'b0;
        chk_en = 1'b1;
        cyc(2);

        // Program 07:30.
        pulse(1, 0, 0);
        check("set_hour_display", 32'({bus.o_Display_Select, bus.o_Display_Enable_Digits}), 32'b110);
        ups(7);
        pulse(1, 0, 0);
        check("set_min_blink", 32'(bus.o_Display_Enable_Digits), 32'b01);
        ups(30);
        pulse(1, 0, 0);
        check("alarm_0730", 32'(alarm_digits()), 32'({2'd0, 4'd7, 3'd3, 4'd0}));
        check("display_back_live", 32'(bus.o_Display_Select), 0);

        // Hour wrap, minute wrap, simultaneous Alarm+Up.
        pulse(1, 0, 0);
        ups(16);
        check("hour_23", 32'({bus.o_Alarm_Tens_Hour, bus.o_Alarm_Units_Hour}), 32'({2'd2, 4'd3}));
        ups(1);
        check("hour_wrap_00", 32'({bus.o_Alarm_Tens_Hour, bus.o_Alarm_Units_Hour}), 0);
        pulse(1, 1, 0);
        check("alarm_up_same_cycle", 32'({bus.o_Display_Enable_Digits, alarm_digits()}),
              32'({2'b01, 2'd0, 4'd0, 3'd3, 4'd0}));
        ups(29);
        check("min_59", 32'({bus.o_Alarm_Tens_Min, bus.o_Alarm_Units_Min}), 32'({3'd5, 4'd9}));
        ups(1);
        check("min_wrap_no_carry", 32'(alarm_digits()), 0);

        // Set-mode timeout keeps the edit.
        ups(5);
        for (int k = 0; k < T_TIMEOUT - 1; k++) tick();
        check("timeout_not_yet", 32'(bus.o_Display_Select), 1);
        tick();
        check("timeout_to_idle", 32'(bus.o_Display_Select), 0);
        check("timeout_kept_min", 32'(alarm_digits()), 32'({2'd0, 4'd0, 3'd0, 4'd5}));

        // Reprogram 07:30.
        pulse(1, 0, 0); ups(7); pulse(1, 0, 0); ups(25); pulse(1, 0, 0);
        check("alarm_0730_again", 32'(alarm_digits()), 32'({2'd0, 4'd7, 3'd3, 4'd0}));

        // Ring on match edge, 60 s auto-stop, no retrigger while held.
        set_live(7, 29);
        pulse(0, 0, 1);
        check("armed_on", 32'(bus.o_Armed), 1);
        cyc(1);
        set_live(7, 30);
        cyc(1);
        check("ring_on_match", 32'(bus.o_Ringing), 1);
        for (int k = 0; k < T_RING - 1; k++) tick();
        check("ring_before_60", 32'(bus.o_Ringing), 1);
        tick();
        check("ring_auto_stop", 32'(bus.o_Ringing), 0);
        cyc(5);
        check("no_retrigger", 32'(bus.o_Ringing), 0);

        // Arm stops ringing, stays armed.
        set_live(7, 31); cyc(1);
        set_live(7, 30); cyc(1);
        check("ring_again", 32'(bus.o_Ringing), 1);
        cyc(3);
        pulse(0, 0, 1);
        check("arm_stop", 32'({bus.o_Ringing, bus.o_Buzzer, bus.o_Armed}), 32'b001);

        // Disarmed at a match: silent.
        set_live(7, 31); cyc(1);
        pulse(0, 0, 1);
        check("disarmed", 32'(bus.o_Armed), 0);
        set_live(7, 30); cyc(3);
        check("disarmed_no_ring", 32'(bus.o_Ringing), 0);

        // Arming while already at the alarm time starts ringing; then Up.
        pulse(0, 0, 1);
        cyc(1);
        check("arm_at_match_rings", 32'(bus.o_Ringing), 1);
        pulse(0, 1, 0);
`ifdef ALARM_SNOOZE_EN
        check("snooze_entered", 32'({bus.o_Ringing, bus.o_Buzzer}), 0);
        tick(); tick();
        check("snooze_holding", 32'(bus.o_Ringing), 0);
        tick();
        check("snooze_rerings", 32'(bus.o_Ringing), 1);
`else
        check("up_ignored_ringing", 32'(bus.o_Ringing), 1);
`endif

        // Asynchronous reset mid-ring while the buzzer is sounding.
        w = 0;
        while (bus.o_Buzzer !== 1'b1 && w < 40) begin
            @(negedge clk);
            w = w + 1;
        end
        check("buzzer_sounding", 32'(w < 40), 1);
        #2 rst = 1'b1;
        #1;
        check("reset_mid_ring_buzzer", 32'({bus.o_Buzzer, bus.o_Ringing}), 0);
        check("reset_mid_ring_time", 32'(alarm_digits()), 0);
        @(negedge clk);
        rst = 1'b0;
        cyc(4);
        check("after_reset_disarmed", 32'(bus.o_Armed), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alarm_controller.md
Name: alarm_controller

Overview:
- Alarm scheduler for the FPGA clock. Holds a BCD alarm time (HH:MM) and sequences alarm setting, arming, ringing and timeout.
- Drives the display source select and digit-blink enables, and gates the buzzer tone.
- Sits beside the time counters and control unit. Takes debounced button release pulses, the 1 Hz enable and the live time digits.

Parameters:
- RING_SEC, 60: seconds the buzzer sounds before auto-stop.
- TIMEOUT_SEC, 10: seconds without a button press before set mode aborts to IDLE.
- SNOOZE_SEC, 300: snooze length in seconds; used only with ALARM_SNOOZE_EN.

Ports:
- i_Clock  in  1  system clock
- i_Reset  in  1  asynchronous, active-high reset
- i_Tick_1Hz  in  1  one-cycle enable, once per second
- i_Tone  in  1  square-wave tone source (e.g. 512 Hz)
- i_Button_Alarm  in  1  one-cycle pulse: enter/advance alarm set mode
- i_Button_Up  in  1  one-cycle pulse: increment field / snooze
- i_Button_Arm  in  1  one-cycle pulse: toggle armed / stop ringing
- i_Units_Min 4, i_Tens_Min 3, i_Units_Hour 4, i_Tens_Hour 2  in  live time digits, BCD
- o_Alarm_Units_Min 4, o_Alarm_Tens_Min 3, o_Alarm_Units_Hour 4, o_Alarm_Tens_Hour 2  out  alarm time, BCD
- o_Display_Select  out  1  1 = display shows alarm time
- o_Display_Enable_Digits  out  2  bit0 = blink minutes pair, bit1 = blink hours pair
- o_Armed  out  1  alarm armed
- o_Ringing  out  1  in RINGING state
- o_Buzzer  out  1  gated tone

Behaviour:
- Reset values: alarm time 00:00; state IDLE; o_Armed 0; o_Buzzer 0; o_Ringing 0; o_Display_Select 0; o_Display_Enable_Digits 00. All counters cleared, match register cleared.
- All outputs are registered. A state change is visible one cycle after the causing pulse.
- States: IDLE, SET_HOUR, SET_MIN, RINGING, and SNOOZE (only when ALARM_SNOOZE_EN is defined).
- IDLE:
  - Alarm pulse -> SET_HOUR.
  - Arm pulse -> toggle o_Armed.
  - Up pulse ignored.
- SET_HOUR:
  - Display select 1, blink enable 10.
  - Up pulse increments hour: 09->10, 19->20, 23->00.
  - Alarm pulse -> SET_MIN.
- SET_MIN:
  - Display select 1, blink enable 01.
  - Up pulse increments minute: 09->10, 59->00. No carry into hour.
  - Alarm pulse -> IDLE.
- Set-mode timeout:
  - Seconds counter is cleared on entry to a set state and on any button pulse; it counts i_Tick_1Hz.
  - Reaching TIMEOUT_SEC returns to IDLE with the edited value kept.
- Simultaneous pulses in a set state: Alarm wins and Up is dropped. Arm is ignored in set states.
- Match:
  - match = o_Armed AND live HH:MM equals alarm HH:MM. It is registered every cycle.
  - A rising edge of match in IDLE -> RINGING.
  - In set states the register still updates but the edge is ignored, so leaving set mode during a match does not ring.
- RINGING:
  - o_Ringing 1. o_Buzzer = i_Tone AND beat. beat is set to 1 on entry and toggles on each i_Tick_1Hz.
  - Ring counter counts ticks; at RING_SEC -> IDLE.
  - Arm or Alarm pulse -> IDLE immediately; o_Armed stays 1.
- Buzzer is 0 in every state except RINGING.
- Asynchronous reset mid-ring or mid-set silences the buzzer immediately and restores alarm 00:00.
- Counter widths are $clog2 of (max parameter + 1).

Optional Feature:
- Macro: ALARM_SNOOZE_EN.
- Defined:
  - Up pulse in RINGING -> SNOOZE: buzzer 0, o_Ringing 0, snooze counter cleared.
  - After SNOOZE_SEC ticks -> RINGING, with the ring counter and beat reinitialised.
  - Arm pulse in SNOOZE -> IDLE.
- Not defined: Up pulse in RINGING is ignored, no SNOOZE state exists, and SNOOZE_SEC is unused.

Decomposition:
- Shared package clock_pkg holds:
  - the state encoding constants (IDLE=0, SET_HOUR=1, SET_MIN=2, RINGING=3, SNOOZE=4);
  - BCD digit widths and the hour/minute limits (23, 59).
- One sub-module, alarm_time_reg: holds the four BCD digits with inc_hour/inc_min strobes and the wrap rules. It is reusable by the time counters.
- The FSM, timeout/ring/snooze counters and match detector stay in alarm_controller.

Test Plan:
- Reset, Alarm pulse, 7x Up, Alarm pulse, 30x Up, Alarm pulse -> alarm 07:30, state IDLE, display select back to 0.
- In SET_HOUR at 23, Up -> 00. In SET_MIN at 59, Up -> 00 with hour unchanged. Alarm and Up in the same cycle -> SET_MIN with value unchanged.
- Enter SET_MIN, then 10 ticks with no buttons -> IDLE; edited minute kept.
- Armed, alarm 07:30, live time steps 07:29 -> 07:30 -> RINGING next cycle. o_Buzzer follows i_Tone on alternate seconds; returns to IDLE after 60 ticks. Live time held at 07:30 -> no retrigger.
- RINGING, then Arm pulse -> IDLE, buzzer 0, o_Armed 1. Disarmed at a match -> no ring. Assert reset mid-ring -> buzzer 0 at once, alarm 00:00.
- With ALARM_SNOOZE_EN and SNOOZE_SEC=3: Up in RINGING -> SNOOZE, then 3 ticks -> RINGING. Without the macro, Up in RINGING leaves state unchanged.
